// File: rtl/bin2bcd_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
// Ports: start/bin (request), busy/done/bcd/ovf (status and held result).
interface bin2bcd_if #(
  parameter int IN_W = 14,
  parameter int NDIG = 4
);
  logic                start;
  logic [IN_W-1:0]     bin;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   bcd;
  logic                ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary to packed BCD, one bit per clock, result held.
// Ports: clk, rst_n (async low), bus (slave: start/bin in; busy/done/bcd/ovf out).
module bin2bcd_seq #(
  parameter int IN_W    = 14,
  parameter int NDIG    = 4,
  parameter int MAX_VAL = 9999
) (
  input logic      clk,
  input logic      rst_n,
  bin2bcd_if.slave bus
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(IN_W);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IN_W-1:0] r_bin;
  logic [BW-1:0]   r_sh;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_lat;
  logic            r_ovf;
  logic            r_done;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_sh_nxt;
  logic            w_accept;
  logic            w_last;

  // Add-3 on every nibble >= 5 before the shift; operand <= 9 so no carry-out.
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < NDIG; i++) begin
      if (r_sh[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_sh[4*i +: 4] + 4'd3;
    end
  end

  assign w_sh_nxt = {w_adj[BW-2:0], r_bin[IN_W-1]};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(IN_W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_ovf_lat <= 1'b0;
    end else if (w_accept) begin
      r_bin     <= bus.bin;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_ovf_lat <= (bus.bin > IN_W'(MAX_VAL));
    end else if (r_state == S_SHIFT) begin
      r_bin     <= r_bin << 1;
      r_sh      <= w_sh_nxt;
      r_cnt     <= r_cnt + CW'(1);
    end
  end

  // Displayed result only moves at the done edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_bcd <= r_ovf_lat ? {NDIG{4'h9}} : w_sh_nxt;
        r_ovf <= r_ovf_lat;
      end
    end
  end

  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: random, directed and sweep stimulus.
// Reference is decimal arithmetic with saturation at 9999.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;

  bin2bcd_if bus ();

  bin2bcd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [16:0] q[$];
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] h_bcd  = '0;
  logic        h_ovf  = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [16:0] ref_conv(int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Timing model: a start seen while idle takes 14 busy cycles, then done.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0;
        m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end else if (bus.start === 1'b1) begin
          m_left = 14;
          q.push_back(ref_conv(int'(bus.bin)));
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done and checks held outputs.
  initial begin
    logic [16:0] e;
    logic        nib_ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        h_bcd = '0;
        h_ovf = 1'b0;
      end
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          h_ovf = e[16];
          h_bcd = e[15:0];
        end
        nib_ok = 1'b1;
        for (int i = 0; i < 4; i++)
          if (bus.bcd[4*i +: 4] > 4'd9) nib_ok = 1'b0;
        chk("nibble_le9", 32'(nib_ok), 32'(1));
      end
      chk("bcd", 32'(bus.bcd), 32'(h_bcd));
      chk("ovf", 32'(bus.ovf), 32'(h_ovf));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic one_conv(int v);
    bus.start = 1'b1;
    bus.bin   = 14'(v);
    step(1);
    bus.start = 1'b0;
    bus.bin   = 14'($urandom);
    step(15);
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    #1 rst_n  = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    one_conv(1234);
    step(2);

    // back-to-back with start held
    bus.start = 1'b1;
    bus.bin   = 14'd0;
    step(1);
    bus.bin   = 14'd9999;
    step(15);
    bus.start = 1'b0;
    step(16);

    one_conv(12000);
    one_conv(42);
    step(2);

    // start while busy is ignored
    bus.start = 1'b1;
    bus.bin   = 14'd5000;
    step(1);
    bus.start = 1'b0;
    step(5);
    bus.start = 1'b1;
    bus.bin   = 14'd7;
    step(1);
    bus.start = 1'b0;
    step(14);

    // reset aborts a conversion
    bus.start = 1'b1;
    bus.bin   = 14'd8765;
    step(1);
    bus.start = 1'b0;
    step(7);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    one_conv(321);

    // random starts, many landing while busy
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.bin   = 14'($urandom_range(0, 16383));
      step(1);
    end
    bus.start = 1'b0;
    step(20);

    // sweep with start held high
    bus.start = 1'b1;
    for (int v = 0; v < 10000; v += 3) begin
      bus.bin = 14'(v);
      step(15);
    end
    bus.bin = 14'd9999;
    step(15);
    bus.start = 1'b0;
    step(20);

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
